// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants and state encoding for the JPEG entropy-coded-segment path
//
// Purpose: holds the constants and the state type that the bit packer and the
// decoder-side unstuffer both use.
// Contents:
//   JPEG_MAX_CODE_LEN - longest code accepted per transfer (16-bit Huffman + 11 magnitude bits)
//   JPEG_STUFF_BYTE   - byte inserted after every emitted 0xFF
//   JPEG_FF           - byte value that triggers stuffing
//   JPEG_PAD_BIT      - value used to fill the final partial byte
//   jpeg_state_e      - RUN / STUFF / PAD / DONE
package jpeg_pkg;

  localparam int         JPEG_MAX_CODE_LEN = 27;
  localparam logic [7:0] JPEG_STUFF_BYTE   = 8'h00;
  localparam logic [7:0] JPEG_FF           = 8'hFF;
  localparam logic       JPEG_PAD_BIT      = 1'b1;

  typedef enum logic [1:0] {
    JPEG_RUN   = 2'd0,
    JPEG_STUFF = 2'd1,
    JPEG_PAD   = 2'd2,
    JPEG_DONE  = 2'd3
  } jpeg_state_e;

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// rtl/jpeg_byte_stuffer.sv - inserts a 0x00 byte after every 0xFF in a valid/ready byte stream
//
// Purpose: byte pass-through that injects a stuff byte after each accepted 0xFF.
// Ports:
//   clk_i, rst_i               - clock, synchronous active-high reset
//   s_tdata_i/s_tvalid_i/s_tready_o - upstream byte stream
//   m_tdata_o/m_tvalid_o/m_tready_i - downstream byte stream
//   stuff_pending_o            - high while the stuff byte is being presented
module jpeg_byte_stuffer
  import jpeg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] s_tdata_i,
  input  logic       s_tvalid_i,
  output logic       s_tready_o,
  output logic [7:0] m_tdata_o,
  output logic       m_tvalid_o,
  input  logic       m_tready_i,
  output logic       stuff_pending_o
);

  logic stuff_q;
  logic stuff_d;

  // Upstream data is forwarded combinationally; upstream is registered, so
  // m_tvalid_o never depends on m_tready_i.
  always_comb begin
    m_tvalid_o      = stuff_q | s_tvalid_i;
    m_tdata_o       = stuff_q ? JPEG_STUFF_BYTE : s_tdata_i;
    s_tready_o      = !stuff_q && m_tready_i;
    stuff_pending_o = stuff_q;
  end

  always_comb begin
    stuff_d = stuff_q;
    if (m_tvalid_o && m_tready_i) begin
      stuff_d = !stuff_q && (s_tdata_i == JPEG_FF);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stuff_q <= 1'b0;
    end else begin
      stuff_q <= stuff_d;
    end
  end

endmodule

// File: rtl/jpeg_bit_packer.sv
// rtl/jpeg_bit_packer.sv - packs variable-length codes MSB-first into a stuffed JPEG byte stream
//
// Purpose: appends right-aligned codes to a 40-bit left-aligned bit buffer,
// emits whole bytes through jpeg_byte_stuffer, and on flush pads the last
// partial byte with 1s before pulsing flush_done.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   in_valid/in_ready              - code transfer handshake
//   code_bits[MAX_LEN-1:0], code_len[LEN_W-1:0] - right-aligned code and its length
//   flush_req/flush_done           - pad-and-drain request, one-cycle completion pulse
//   out_byte/out_valid/out_ready   - output byte stream
//   byte_count, stuff_count        - only when JPEG_PACKER_STATS_EN is defined
// Build option: define JPEG_PACKER_STATS_EN to add the saturating statistics counters.
module jpeg_bit_packer
  import jpeg_pkg::*;
#(
  parameter int MAX_LEN = JPEG_MAX_CODE_LEN,
  parameter int LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] code_bits,
  input  logic [LEN_W-1:0]   code_len,
  input  logic               flush_req,
  output logic               flush_done,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready
`ifdef JPEG_PACKER_STATS_EN
  ,
  output logic [31:0]        byte_count,
  output logic [15:0]        stuff_count
`endif
);

  localparam int BUF_W = 40;

  localparam logic [1:0] ST_RUN  = JPEG_RUN;
  localparam logic [1:0] ST_PAD  = JPEG_PAD;
  localparam logic [1:0] ST_DONE = JPEG_DONE;

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;

  logic [LEN_W-1:0] len_sat;
  logic [BUF_W-1:0] code_ext;
  logic [BUF_W-1:0] append;
  logic [5:0]       sh;

  logic             s_tvalid;
  logic             s_tready;
  logic             stuff_busy;
  logic             pop;
  logic             take;

  jpeg_byte_stuffer u_stuffer (
    .clk_i           (clk),
    .rst_i           (rst),
    .s_tdata_i       (buf_q[BUF_W-1 -: 8]),
    .s_tvalid_i      (s_tvalid),
    .s_tready_o      (s_tready),
    .m_tdata_o       (out_byte),
    .m_tvalid_o      (out_valid),
    .m_tready_i      (out_ready),
    .stuff_pending_o (stuff_busy)
  );

  always_comb begin
    len_sat  = (code_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : code_len;
    // Mask off bits at and above code_len, then move the code just below the
    // residual bits. sh is at least 40-7-27 = 6, so nothing falls off the top.
    code_ext = {{(BUF_W-MAX_LEN){1'b0}}, code_bits} & ~({BUF_W{1'b1}} << len_sat);
    sh       = 6'(BUF_W) - cnt_q - 6'(len_sat);
    append   = code_ext << sh;
  end

  always_comb begin
    s_tvalid   = (state_q == ST_RUN) && (cnt_q >= 6'd8);
    pop        = s_tvalid && s_tready;
    // rst gating keeps in_ready low during the reset cycle itself.
    in_ready   = !rst && (state_q == ST_RUN) && !stuff_busy && (cnt_q < 6'd8) && !flush_req;
    take       = in_valid && in_ready;
    flush_done = (state_q == ST_DONE);
  end

  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        // pop and take are mutually exclusive through the cnt_q >= 8 split.
        if (pop) begin
          buf_d = buf_q << 8;
          cnt_d = cnt_q - 6'd8;
        end else if (take) begin
          buf_d = buf_q | append;
          cnt_d = cnt_q + 6'(len_sat);
        end else if (flush_req && !stuff_busy && (cnt_q < 6'd8)) begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (cnt_q != 6'd0) begin
          // Bits below the residual are always zero, so OR-ing in the pad works.
          buf_d[BUF_W-1 -: 8] = buf_q[BUF_W-1 -: 8] | ({8{JPEG_PAD_BIT}} >> cnt_q[2:0]);
          cnt_d   = 6'd8;
          state_d = ST_RUN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

`ifdef JPEG_PACKER_STATS_EN
  logic [31:0] byte_cnt_q;
  logic [15:0] stuff_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q  <= '0;
      stuff_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      if (byte_cnt_q != '1) begin
        byte_cnt_q <= byte_cnt_q + 32'd1;
      end
      if (stuff_busy && (stuff_cnt_q != '1)) begin
        stuff_cnt_q <= stuff_cnt_q + 16'd1;
      end
    end
  end

  assign byte_count  = byte_cnt_q;
  assign stuff_count = stuff_cnt_q;
`endif

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// tb/tb_jpeg_bit_packer.sv - directed self-checking bench for jpeg_bit_packer
module tb_jpeg_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] code_bits;
  logic [4:0]  code_len;
  logic        flush_req;
  logic        flush_done;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  int done_cnt = 0;

  jpeg_bit_packer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge they hold for the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) q.push_back(out_byte);
      if (flush_done) done_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [26:0] c, input logic [4:0] l);
    logic ok;
    ok = 1'b0;
    code_bits = c;
    code_len  = l;
    in_valid  = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready=0 required 1 (len %0d)", l);
    end
  endtask

  task automatic flush();
    logic seen;
    seen = 1'b0;
    flush_req = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = flush_done;
      @(posedge clk);
      #1;
    end
    flush_req = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL flush_timeout: flush_done=0 required 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush_req = 1'b0; out_ready = 1'b0;
    code_bits = '0; code_len = '0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_byte !== 8'h00 || flush_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_byte=%h flush_done=%b want 1 0 00 0",
               in_ready, out_valid, out_byte, flush_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pack_bf();
    out_ready = 1'b1;
    q.delete();
    send(27'b101, 5'd3);
    send(27'b11111, 5'd5);
    idle(4);
    checks++;
    if (q.size() != 1) begin
      errors++; $display("FAIL pack_bf_count: got %0d bytes want 1", q.size());
    end else if (q[0] !== 8'hBF) begin
      errors++; $display("FAIL pack_bf_value: got %h want bf", q[0]);
    end
  endtask

  task automatic test_ff_stuff();
    q.delete();
    send(27'hFF, 5'd8);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'hFF) begin
      errors++; $display("FAIL ff_first: valid=%b byte=%h want 1 ff", out_valid, out_byte);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'h00 || in_ready !== 1'b0) begin
      errors++; $display("FAIL ff_stuff: valid=%b byte=%h in_ready=%b want 1 00 0",
                         out_valid, out_byte, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ff_after: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (q.size() != 2 || q[0] !== 8'hFF || q[1] !== 8'h00) begin
      errors++; $display("FAIL ff_seq: got %0d bytes want ff 00", q.size());
    end
  endtask

  task automatic test_flush_pad();
    q.delete();
    done_cnt = 0;
    send(27'b010, 5'd3);
    flush();
    idle(3);
    checks++;
    if (q.size() != 1 || q[0] !== 8'h5F) begin
      errors++; $display("FAIL pad_byte: got %0d bytes first %h want 1 byte 5f", q.size(),
                         (q.size() > 0) ? q[0] : 8'hxx);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL pad_done_pulses: got %0d want 1", done_cnt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL pad_empty: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [7:0] exp [8];
    logic stable;
    exp = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    q.delete();
    out_ready = 1'b0;
    send(27'h7FFFFFF, 5'd27);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_byte === 8'hFF && in_ready === 1'b0)) stable = 1'b0;
    end
    checks++;
    if (!stable || q.size() != 0) begin
      errors++; $display("FAIL stall_hold: stable=%b bytes=%0d want 1 0", stable, q.size());
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    flush();
    idle(3);
    checks++;
    if (q.size() != 8) begin
      errors++; $display("FAIL stall_count: got %0d bytes want 8", q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (q[i] !== exp[i]) begin
          errors++; $display("FAIL stall_seq[%0d]: got %h want %h", i, q[i], exp[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_len_edges();
    logic [7:0] exp [8];
    exp = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    q.delete();
    send(27'h1234567, 5'd0);
    idle(3);
    @(negedge clk);
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL len0_noop: bytes=%0d valid=%b want 0 0", q.size(), out_valid);
    end
    @(posedge clk); #1;
    send(27'h7FFFFFF, 5'd31);
    idle(10);
    checks++;
    if (q.size() != 6) begin
      errors++; $display("FAIL len31_count: got %0d bytes want 6", q.size());
    end
    flush();
    idle(3);
    checks++;
    if (q.size() != 8) begin
      errors++; $display("FAIL len31_total: got %0d bytes want 8", q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (q[i] !== exp[i]) begin
          errors++; $display("FAIL len31_seq[%0d]: got %h want %h", i, q[i], exp[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    out_ready = 1'b0;
    send(27'hFF, 5'd8);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'hFF) begin
      errors++; $display("FAIL rstmid_pre: valid=%b byte=%h want 1 ff", out_valid, out_byte);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_post: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    idle(3);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rstmid_no_stuff: got %0d bytes want 0", q.size());
    end
    done_cnt = 0;
    flush();
    idle(2);
    checks++;
    if (q.size() != 0 || done_cnt != 1) begin
      errors++; $display("FAIL rstmid_flush: bytes=%0d done=%0d want 0 1", q.size(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_pack_bf();
    test_ff_stuff();
    test_flush_pad();
    test_stall();
    test_len_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
